hex_step_scheduler: RTL and testbench

Sequencing controller for the five-position digit display on HEX0. It arbitrates step requests between the manual KEY step button and a free-running auto-advance timer, and advances a one-hot position register in either direction with wrap-around. It also drives the seven-segment pattern for the displayed sequence 3-1-4-5-8. It sits between the board inputs (KEY, SW) and HEX0, and replaces direct clocking of the display FSM from a push button.

---
 rtl/hex_step_scheduler.sv | 139 +++++++++++++
 tb/tb_hex_step_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_step_scheduler.sv
// hex_step_scheduler
// Drives HEX0 through the five-position sequence 3-1-4-5-8. A step can come
// from the KEY button or from a free-running auto-advance timer. Each step
// moves a one-hot position register forward or backward, wrapping at both ends.
//
// Ports
//   CLK         system clock, rising edge
//   RST         asynchronous active-high reset
//   key_step    manual step request (level, asynchronous to CLK)
//   dir         0 = forward, 1 = backward; sampled in the step cycle
//   auto_en     enables the auto-advance timer (0 clears it)
//   hold        freezes the auto-advance timer; manual steps still accepted
//   state       one-hot display position, 5'b00001 = first digit
//   step_pulse  one cycle high when a new position first becomes visible
//   src         source of the most recent step (0 manual, 1 auto)
//   HEX0        active-high segment pattern, bit order gfedcba
//
// state  | meaning
// 00001  | digit "3"
// 00010  | digit "1"
// 00100  | digit "4"
// 01000  | digit "5"
// 10000  | digit "8"
// other  | illegal, forced to 00001 on the next edge without a step pulse
module hex_step_scheduler #(
    parameter int DIV_WIDTH = 26,
    parameter int DIV_MAX   = 49_999_999
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       key_step,
    input  logic       dir,
    input  logic       auto_en,
    input  logic       hold,
    output logic [4:0] state,
    output logic       step_pulse,
    output logic       src,
    output logic [6:0] HEX0
);

    localparam logic [DIV_WIDTH-1:0] CNT_MAX = DIV_WIDTH'(DIV_MAX);
    localparam logic [DIV_WIDTH-1:0] CNT_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    logic                 s1_q, s2_q, prev_q;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [4:0]           state_q, state_d;
    logic                 pulse_q, pulse_d;
    logic                 src_q, src_d;

    logic man_req;
    logic auto_req;
    logic step;
    logic legal;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= 5'b00001;
            pulse_q <= 1'b0;
            src_q   <= 1'b0;
        end else begin
            s1_q    <= key_step;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            pulse_q <= pulse_d;
            src_q   <= src_d;
        end
    end

    assign man_req  = s2_q & ~prev_q;
    assign auto_req = auto_en & ~hold & (cnt_q == CNT_MAX);
    assign step     = man_req | auto_req;

    // A manual step restarts the period so the next auto step is a full
    // period away; a coincident auto request is simply dropped.
    always_comb begin
        cnt_d = cnt_q;
        if (!auto_en) begin
            cnt_d = '0;
        end else if (man_req) begin
            cnt_d = '0;
        end else if (!hold) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        legal = 1'b0;
        case (state_q)
            5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Rotation handles both wrap cases: 10000 -> 00001 forward and
    // 00001 -> 10000 backward.
    always_comb begin
        state_d = state_q;
        pulse_d = 1'b0;
        src_d   = src_q;
        if (!legal) begin
            state_d = 5'b00001;
        end else if (step) begin
            pulse_d = 1'b1;
            src_d   = ~man_req;
            if (dir) begin
                state_d = {state_q[0], state_q[4:1]};
            end else begin
                state_d = {state_q[3:0], state_q[4]};
            end
        end
    end

    always_comb begin
        HEX0 = 7'b0000000;
        case (state_q)
            5'b00001: HEX0 = 7'b1001111;
            5'b00010: HEX0 = 7'b0000110;
            5'b00100: HEX0 = 7'b1100110;
            5'b01000: HEX0 = 7'b1101101;
            5'b10000: HEX0 = 7'b1111111;
            default:  HEX0 = 7'b0000000;
        endcase
    end

    assign state      = state_q;
    assign step_pulse = pulse_q;
    assign src        = src_q;

endmodule

// File: tb/tb_hex_step_scheduler.sv
module tb_hex_step_scheduler;

    logic       CLK = 1'b0;
    logic       RST;
    logic       key_step;
    logic       dir;
    logic       auto_en;
    logic       hold;
    logic [4:0] state;
    logic       step_pulse;
    logic       src;
    logic [6:0] HEX0;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    typedef struct {
        logic [4:0] st;
        logic       src;
        logic [6:0] hex;
        int         at_edge;
    } exp_t;

    exp_t sb[$];
    logic [4:0] model_st;

    hex_step_scheduler #(.DIV_WIDTH(4), .DIV_MAX(3)) dut (
        .CLK(CLK), .RST(RST), .key_step(key_step), .dir(dir),
        .auto_en(auto_en), .hold(hold), .state(state),
        .step_pulse(step_pulse), .src(src), .HEX0(HEX0)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or posedge RST) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests_run++;
        assert (obs === exp_v) else begin
            tests_failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [6:0] hex_of(input logic [4:0] p);
        case (p)
            5'b00001: return 7'b1001111;
            5'b00010: return 7'b0000110;
            5'b00100: return 7'b1100110;
            5'b01000: return 7'b1101101;
            5'b10000: return 7'b1111111;
            default:  return 7'b0000000;
        endcase
    endfunction

    function automatic logic [4:0] next_pos(input logic [4:0] p, input logic back);
        case (p)
            5'b00001: return back ? 5'b10000 : 5'b00010;
            5'b00010: return back ? 5'b00001 : 5'b00100;
            5'b00100: return back ? 5'b00010 : 5'b01000;
            5'b01000: return back ? 5'b00100 : 5'b10000;
            default:  return back ? 5'b01000 : 5'b00001;
        endcase
    endfunction

    task automatic expect_step(input logic back, input logic s, input int at_edge);
        exp_t e;
        model_st  = next_pos(model_st, back);
        e.st      = model_st;
        e.src     = s;
        e.hex     = hex_of(model_st);
        e.at_edge = at_edge;
        sb.push_back(e);
    endtask

    // Scoreboard consumer: every visible step must match the oldest expectation.
    always @(negedge CLK) begin
        if (!RST && step_pulse) begin
            if (sb.size() == 0) begin
                check("unexpected_step", {31'd0, step_pulse}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("step_state", {27'd0, state}, {27'd0, e.st});
                check("step_src", {31'd0, src}, {31'd0, e.src});
                check("step_hex", {25'd0, HEX0}, {25'd0, e.hex});
                if (e.at_edge >= 0)
                    check("step_edge", cyc, e.at_edge);
            end
        end
    end

    task automatic goto_cyc(input int n);
        for (int i = 0; i < 200 && cyc < n; i++) @(negedge CLK);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge CLK);
        check(tag, sb.size(), 0);
        sb.delete();
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        model_st = 5'b00001;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; key_step = 1'b0; dir = 1'b0; auto_en = 1'b0; hold = 1'b0;
        model_st = 5'b00001;
        repeat (2) @(negedge CLK);
        check("rst_state", {27'd0, state}, 32'h01);
        check("rst_pulse", {31'd0, step_pulse}, 32'd0);
        check("rst_src", {31'd0, src}, 32'd0);
        check("rst_hex", {25'd0, HEX0}, 32'h4F);
        check("rst_cnt", {28'd0, dut.cnt_q}, 32'd0);
        RST = 1'b0;

        // Manual steps forward with wrap, latency of three edges from drive.
        for (int i = 0; i < 5; i++) begin
            expect_step(1'b0, 1'b0, cyc + 3);
            key_step = 1'b1;
            repeat (4) @(negedge CLK);
            key_step = 1'b0;
            repeat (4) @(negedge CLK);
        end
        drain("manual_drain");
        check("manual_wrap_state", {27'd0, state}, 32'h01);

        // Illegal positions recover to the first digit without a pulse.
        force dut.state_q = 5'b00110;
        #1;
        check("illegal_hex_00110", {25'd0, HEX0}, 32'd0);
        release dut.state_q;
        @(negedge CLK);
        check("illegal_fix_00110", {27'd0, state}, 32'h01);
        check("illegal_pulse_00110", {31'd0, step_pulse}, 32'd0);
        force dut.state_q = 5'b00000;
        #1;
        check("illegal_hex_00000", {25'd0, HEX0}, 32'd0);
        release dut.state_q;
        @(negedge CLK);
        check("illegal_fix_00000", {27'd0, state}, 32'h01);
        check("illegal_pulse_00000", {31'd0, step_pulse}, 32'd0);

        // Auto-advance backward from reset: steps at edges 4, 8, 12.
        auto_en = 1'b1; dir = 1'b1;
        apply_reset();
        expect_step(1'b1, 1'b1, 4);
        expect_step(1'b1, 1'b1, 8);
        expect_step(1'b1, 1'b1, 12);
        goto_cyc(13);
        auto_en = 1'b0;
        drain("auto_drain");

        // Manual request coincides with counter at terminal: one manual step,
        // next auto step a full period later.
        auto_en = 1'b1; dir = 1'b0;
        apply_reset();
        goto_cyc(1);
        expect_step(1'b0, 1'b0, 4);
        expect_step(1'b0, 1'b1, 8);
        key_step = 1'b1;
        goto_cyc(5);
        key_step = 1'b0;
        goto_cyc(10);
        auto_en = 1'b0;
        drain("arb_drain");

        // Hold freezes the counter; manual press during hold still steps.
        auto_en = 1'b1; dir = 1'b0;
        apply_reset();
        expect_step(1'b0, 1'b1, 4);
        goto_cyc(6);
        check("hold_cnt_start", {28'd0, dut.cnt_q}, 32'd2);
        hold = 1'b1;
        goto_cyc(11);
        check("hold_cnt_mid", {28'd0, dut.cnt_q}, 32'd2);
        goto_cyc(16);
        check("hold_cnt_end", {28'd0, dut.cnt_q}, 32'd2);
        hold = 1'b0;
        expect_step(1'b0, 1'b1, 18);
        goto_cyc(19);
        check("hold2_cnt", {28'd0, dut.cnt_q}, 32'd1);
        hold = 1'b1;
        key_step = 1'b1;
        expect_step(1'b0, 1'b0, 22);
        goto_cyc(21);
        check("hold2_cnt_frozen", {28'd0, dut.cnt_q}, 32'd1);
        goto_cyc(23);
        check("hold2_cnt_cleared", {28'd0, dut.cnt_q}, 32'd0);
        key_step = 1'b0;
        goto_cyc(24);
        hold = 1'b0;
        expect_step(1'b0, 1'b1, 28);
        goto_cyc(29);
        auto_en = 1'b0;
        drain("hold_drain");

        // Reset mid-operation with a press in the synchronizer.
        auto_en = 1'b1; dir = 1'b0;
        apply_reset();
        expect_step(1'b0, 1'b1, 4);
        goto_cyc(5);
        key_step = 1'b1;
        goto_cyc(6);
        check("mid_cnt", {28'd0, dut.cnt_q}, 32'd2);
        check("mid_s1", {31'd0, dut.s1_q}, 32'd1);
        check("mid_sb_empty", sb.size(), 0);
        RST = 1'b1;
        key_step = 1'b0;
        #1;
        check("mid_rst_state", {27'd0, state}, 32'h01);
        check("mid_rst_src", {31'd0, src}, 32'd0);
        check("mid_rst_cnt", {28'd0, dut.cnt_q}, 32'd0);
        check("mid_rst_s1", {31'd0, dut.s1_q}, 32'd0);
        check("mid_rst_hex", {25'd0, HEX0}, 32'h4F);
        auto_en = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        model_st = 5'b00001;
        repeat (10) @(negedge CLK);
        check("mid_no_step_state", {27'd0, state}, 32'h01);

        // key_step held high across reset release: exactly one step.
        key_step = 1'b1;
        apply_reset();
        expect_step(1'b0, 1'b0, -1);
        repeat (8) @(negedge CLK);
        key_step = 1'b0;
        drain("held_key_drain");
        repeat (4) @(negedge CLK);
        check("held_key_state", {27'd0, state}, 32'h02);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
